// File: rtl/mmio_hub.sv
// Memory-mapped load/store hub: steers memory-stage requests to data memory or
// to IO_CH registered output / debounced input channels, with a valid/ready handshake.

module mmio_in_chan #(
   parameter int CH_W    = 16,
   parameter int DEB_CYC = 4
) (
   input  logic            clock,
   input  logic            rst,
   input  logic [CH_W-1:0] raw,
   output logic [CH_W-1:0] stable
);
   localparam int CNT_W = $clog2(DEB_CYC) + 1;

   logic [CH_W-1:0]  sync1, sync2, stab;
   logic [CNT_W-1:0] cnt;

   // A new synced value must persist DEB_CYC consecutive samples before it is accepted.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
         stab  <= '0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == stab) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEB_CYC - 1)) begin
            stab <= sync2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign stable = stab;
endmodule

module mmio_hub #(
   parameter int                DATA_W  = 32,
   parameter int                IO_CH   = 2,
   parameter int                CH_W    = 16,
   parameter int                MEM_LAT = 1,
   parameter int                DEB_CYC = 4,
   parameter logic [DATA_W-1:0] IO_BASE = DATA_W'(32'hFFFF_FC00)
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [DATA_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [DATA_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic [IO_CH*CH_W-1:0] io_in,
   output logic [IO_CH*CH_W-1:0] io_out
);
   localparam int LAT_W = $clog2(MEM_LAT) + 1;

   typedef enum logic [1:0] {IDLE, MEM_WAIT, RESP} state_t;

   state_t                      state_q, state_d;
   logic [LAT_W-1:0]            lat_q, lat_d;
   logic [DATA_W-1:0]           rdata_q, rdata_d, io_rdata;
   logic [IO_CH-1:0][CH_W-1:0]  out_q, in_stab;
   logic                        is_io, io_is_out, accept, mem_acc;
   logic [6:0]                  io_k;

   genvar g;
   generate
      for (g = 0; g < IO_CH; g++) begin : g_in
         mmio_in_chan #(.CH_W(CH_W), .DEB_CYC(DEB_CYC)) u_in (
            .clock  (clock),
            .rst    (rst),
            .raw    (io_in[g*CH_W +: CH_W]),
            .stable (in_stab[g])
         );
      end
   endgenerate

   assign is_io     = (req_addr[DATA_W-1:10] == IO_BASE[DATA_W-1:10]);
   assign io_k      = req_addr[9:3];
   assign io_is_out = req_addr[2];
   assign accept    = req_valid && (state_q == IDLE);
   assign mem_acc   = accept && !is_io;

   assign mem_en    = mem_acc;
   assign mem_we    = mem_acc && req_write;
   assign mem_addr  = mem_acc ? req_addr  : '0;
   assign mem_wdata = mem_acc ? req_wdata : '0;
   assign io_out    = out_q;

   // Channel numbers at or beyond IO_CH match no entry and read as zero.
   always_comb begin
      io_rdata = '0;
      for (int k = 0; k < IO_CH; k++) begin
         if (io_k == 7'(k))
            io_rdata = DATA_W'(io_is_out ? out_q[k] : in_stab[k]);
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         out_q <= '0;
      end else if (accept && is_io && req_write && io_is_out) begin
         for (int k = 0; k < IO_CH; k++) begin
            if (io_k == 7'(k))
               out_q[k] <= req_wdata[CH_W-1:0];
         end
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         lat_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      rdata_d   = rdata_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (!is_io && !req_write) begin
                  lat_d   = LAT_W'(MEM_LAT - 1);
                  state_d = MEM_WAIT;
               end else begin
                  rdata_d = (is_io && !req_write) ? io_rdata : '0;
                  state_d = RESP;
               end
            end
         end
         MEM_WAIT: begin
            if (lat_q == '0) begin
               rdata_d = mem_rdata;
               state_d = RESP;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rsp_rdata = rsp_valid ? rdata_q : '0;
endmodule

// File: tb/tb_mmio_hub.sv
// Bench for mmio_hub: table vectors, hand-timed debounce/reset sequences and a
// randomized run against a transaction-level reference model.

module tb_mmio_hub;
   localparam int DATA_W  = 32;
   localparam int IO_CH   = 2;
   localparam int CH_W    = 16;
   localparam int MEM_LAT = 3;
   localparam int DEB_CYC = 4;

   logic                  clock, rst;
   logic                  req_valid, req_ready, req_write;
   logic [DATA_W-1:0]     req_addr, req_wdata;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  mem_en, mem_we;
   logic [DATA_W-1:0]     mem_addr, mem_wdata, mem_rdata;
   logic [IO_CH*CH_W-1:0] io_in, io_out;

   int n_chk  = 0;
   int n_fail = 0;
   bit rand_io = 0;

   mmio_hub #(.DATA_W(DATA_W), .IO_CH(IO_CH), .CH_W(CH_W), .MEM_LAT(MEM_LAT),
              .DEB_CYC(DEB_CYC), .IO_BASE(32'hFFFF_FC00)) dut (
      .clock(clock), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .io_in(io_in), .io_out(io_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Data memory device: MEM_LAT-deep read pipe, poison data when no read was issued.
   logic [31:0] dmem [64];
   logic [31:0] rd_pipe [MEM_LAT];
   logic        mem_init_done = 1'b0;
   always @(posedge clock) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 64; i++) dmem[i] <= 32'h1000_0000 + i;
         mem_init_done <= 1'b1;
      end else if (mem_en && mem_we) begin
         dmem[mem_addr[7:2]] <= mem_wdata;
      end
      rd_pipe[0] <= (mem_en && !mem_we) ? dmem[mem_addr[7:2]] : 32'hBAD0_0BAD;
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[MEM_LAT-1];

   // Input-path model: stable takes the synced value once the last DEB_CYC synced
   // samples all differ from it.
   logic [CH_W-1:0] m_s1 [IO_CH], m_s2 [IO_CH], m_stab [IO_CH];
   logic [CH_W-1:0] m_hist [IO_CH][DEB_CYC];

   function automatic bit all_differ(input int c);
      for (int i = 0; i < DEB_CYC - 1; i++)
         if (m_hist[c][i] == m_stab[c]) return 1'b0;
      return m_s2[c] != m_stab[c];
   endfunction

   always @(posedge clock or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < IO_CH; c++) begin
            m_s1[c] <= '0; m_s2[c] <= '0; m_stab[c] <= '0;
            for (int i = 0; i < DEB_CYC; i++) m_hist[c][i] <= '0;
         end
      end else begin
         for (int c = 0; c < IO_CH; c++) begin
            m_s1[c] <= io_in[c*CH_W +: CH_W];
            m_s2[c] <= m_s1[c];
            m_hist[c][0] <= m_s2[c];
            for (int i = 1; i < DEB_CYC; i++) m_hist[c][i] <= m_hist[c][i-1];
            if (all_differ(c)) m_stab[c] <= m_s2[c];
         end
      end
   end

   // Background input activity for the randomized phase.
   initial forever begin
      @(negedge clock);
      if (rand_io && $urandom_range(0, 5) == 0) begin
         int c;
         c = $urandom_range(0, IO_CH - 1);
         case ($urandom_range(0, 3))
            0: io_in[c*CH_W +: CH_W] = 16'h0000;
            1: io_in[c*CH_W +: CH_W] = 16'hFFFF;
            2: io_in[c*CH_W +: CH_W] = 16'hA5A5;
            default: io_in[c*CH_W +: CH_W] = CH_W'($urandom);
         endcase
      end
   end

   // Transaction-level reference state.
   logic [CH_W-1:0] m_out [IO_CH];
   logic [31:0]     ref_mem [64];

   function automatic bit in_io(input logic [31:0] a);
      return a[31:10] == 22'h3F_FFFF;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int off, k, r;
      if (!in_io(a)) return ref_mem[a[7:2]];
      off = int'(a[9:0]);
      k = off / 8;
      r = off % 8;
      if (k >= IO_CH) return 32'h0;
      return (r < 4) ? {16'h0, m_stab[k]} : {16'h0, m_out[k]};
   endfunction

   function automatic void model_store(input logic [31:0] a, input logic [31:0] wd);
      int off, k, r;
      if (!in_io(a)) begin
         ref_mem[a[7:2]] = wd;
      end else begin
         off = int'(a[9:0]);
         k = off / 8;
         r = off % 8;
         if (k < IO_CH && r >= 4) m_out[k] = wd[CH_W-1:0];
      end
   endfunction

   function automatic logic [31:0] exp_io();
      logic [31:0] v;
      v = '0;
      for (int c = 0; c < IO_CH; c++) v[c*CH_W +: CH_W] = m_out[c];
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (!req_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (t >= 50) check("wait_ready timeout", 32'(req_ready), 32'h1);
   endtask

   // Issue one request at a negedge with req_ready high; valid is held until rsp_valid.
   task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic [31:0] idle_rd,
                         output int lat, output int men, output int rdy);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
      #1;
      men = int'(mem_en);
      idle_rd = rsp_rdata;
      rdy = 0;
      @(negedge clock);
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         men += int'(mem_en);
         rdy += int'(req_ready);
         @(negedge clock);
         lat++;
      end
      men += int'(mem_en);
      rdy += int'(req_ready);
      rd = rsp_rdata;
      if (!rsp_valid) lat = -1;
      req_valid = 1'b0;
   endtask

   task automatic xact(input string tag, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
      logic [31:0] rd, idle_rd;
      int lat, men, rdy;
      wait_ready();
      do_req(wr, a, wd, rd, idle_rd, lat, men, rdy);
      check({tag, " rdata"}, rd, exp_rd);
      check({tag, " rdata_idle"}, idle_rd, 32'h0);
      check({tag, " latency"}, 32'(lat), (!in_io(a) && !wr) ? 32'(MEM_LAT + 1) : 32'h1);
      check({tag, " mem_en_pulses"}, 32'(men), in_io(a) ? 32'h0 : 32'h1);
      check({tag, " ready_while_busy"}, 32'(rdy), 32'h0);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [31:0] exp_io;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic [31:0] a, wd, e;
      bit wr;
      int cnt;

      tbl[0]  = '{1'b1, 32'hFFFF_FC0C, 32'h1234_ABCD, 32'h0000_0000, 32'hABCD_0000};
      tbl[1]  = '{1'b0, 32'hFFFF_FC0C, 32'h0,         32'h0000_ABCD, 32'hABCD_0000};
      tbl[2]  = '{1'b1, 32'hFFFF_FC04, 32'hFFFF_5555, 32'h0000_0000, 32'hABCD_5555};
      tbl[3]  = '{1'b0, 32'hFFFF_FC04, 32'h0,         32'h0000_5555, 32'hABCD_5555};
      tbl[4]  = '{1'b0, 32'hFFFF_FC08, 32'h0,         32'h0000_0000, 32'hABCD_5555};
      tbl[5]  = '{1'b0, 32'hFFFF_FC00, 32'h0,         32'h0000_FFFF, 32'hABCD_5555};
      tbl[6]  = '{1'b1, 32'hFFFF_FC00, 32'h0000_0077, 32'h0000_0000, 32'hABCD_5555};
      tbl[7]  = '{1'b0, 32'hFFFF_FC80, 32'h0,         32'h0000_0000, 32'hABCD_5555};
      tbl[8]  = '{1'b1, 32'hFFFF_FC14, 32'h0000_BEEF, 32'h0000_0000, 32'hABCD_5555};
      tbl[9]  = '{1'b0, 32'hFFFF_FC14, 32'h0,         32'h0000_0000, 32'hABCD_5555};
      tbl[10] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 32'hABCD_5555};
      tbl[11] = '{1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 32'hABCD_5555};
      tbl[12] = '{1'b0, 32'hFFFF_FC0E, 32'h0,         32'h0000_ABCD, 32'hABCD_5555};
      tbl[13] = '{1'b0, 32'hFFFF_F80C, 32'h0,         32'h1000_0003, 32'hABCD_5555};

      for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1000_0000 + i;
      for (int c = 0; c < IO_CH; c++) m_out[c] = '0;

      // Reset with channel 0 inputs high.
      rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      io_in = 32'h0000_FFFF;
      repeat (3) @(negedge clock);
      check("reset req_ready", 32'(req_ready), 32'h1);
      check("reset io_out", io_out, 32'h0);
      check("reset rsp_valid", 32'(rsp_valid), 32'h0);
      check("reset rsp_rdata", rsp_rdata, 32'h0);
      check("reset mem_en", 32'(mem_en), 32'h0);
      rst = 1'b1;
      xact("load_in_after_reset", 1'b0, 32'hFFFF_FC00, 32'h0, 32'h0);
      repeat (5) @(negedge clock);
      xact("load_in_debounced", 1'b0, 32'hFFFF_FC00, 32'h0, 32'h0000_FFFF);

      // Table vectors.
      for (int i = 0; i < 14; i++) begin
         xact($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);
         check($sformatf("vec%0d io_out", i), io_out, tbl[i].exp_io);
         if (tbl[i].wr) model_store(tbl[i].addr, tbl[i].wdata);
      end

      // Debounce boundaries on channel 0 bit 0.
      io_in = 32'h0;
      repeat (12) @(negedge clock);
      xact("deb_base", 1'b0, 32'hFFFF_FC00, 32'h0, 32'h0);
      wait_ready();
      io_in = 32'h1;
      repeat (3) @(negedge clock);
      io_in = 32'h0;
      repeat (10) @(negedge clock);
      xact("deb_glitch3", 1'b0, 32'hFFFF_FC00, 32'h0, 32'h0);
      wait_ready();
      io_in = 32'h1;
      repeat (5) @(negedge clock);
      xact("deb_early", 1'b0, 32'hFFFF_FC00, 32'h0, 32'h0);
      repeat (3) @(negedge clock);
      xact("deb_held", 1'b0, 32'hFFFF_FC00, 32'h0, 32'h1);
      io_in = 32'h0;
      repeat (12) @(negedge clock);
      wait_ready();
      io_in = 32'h1;
      repeat (4) @(negedge clock);
      io_in = 32'h0;
      repeat (2) @(negedge clock);
      xact("deb_hold4", 1'b0, 32'hFFFF_FC00, 32'h0, 32'h1);
      repeat (12) @(negedge clock);

      // Reset while a memory load is pending.
      wait_ready();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040;
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      rst = 1'b0;
      #1;
      check("midreset req_ready", 32'(req_ready), 32'h1);
      check("midreset rsp_valid", 32'(rsp_valid), 32'h0);
      check("midreset io_out", io_out, 32'h0);
      for (int c = 0; c < IO_CH; c++) m_out[c] = '0;
      repeat (2) @(negedge clock);
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cnt += int'(rsp_valid);
         @(negedge clock);
      end
      check("midreset no rsp", 32'(cnt), 32'h0);
      xact("after_midreset", 1'b0, 32'hFFFF_FC04, 32'h0, 32'h0);

      // Randomized traffic against the reference model.
      rand_io = 1'b1;
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0: a = 32'($urandom_range(0, 255));
            1: a = 32'hFFFF_FC00 | 32'($urandom_range(0, IO_CH - 1) * 8) | 32'($urandom_range(0, 7));
            2: a = 32'hFFFF_FC00 | 32'($urandom_range(0, 1023));
            default: a = 32'hFFFF_FC04 | 32'($urandom_range(0, IO_CH - 1) * 8) | 32'($urandom_range(0, 3));
         endcase
         wr = 1'($urandom_range(0, 1));
         wd = $urandom;
         wait_ready();
         repeat ($urandom_range(0, 2)) @(negedge clock);
         e = wr ? 32'h0 : model_read(a);
         xact($sformatf("rnd%0d", i), wr, a, wd, e);
         if (wr) model_store(a, wd);
         check($sformatf("rnd%0d io_out", i), io_out, exp_io());
      end
      rand_io = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
